// File: rtl/sbp_result_collect_if.sv
// Handshake and status bundle between the lookup pipeline tail, the result
// consumer and the injector credit path of sbp_result_collect.
interface sbp_result_collect_if #(
  parameter int STAGE_ID_BITS = 6,
  parameter int LOCATION_BITS = 11,
  parameter int DEPTH         = 64
);
  localparam int RESULT_BITS = 1 + LOCATION_BITS + 2 + STAGE_ID_BITS;
  localparam int CNT_BITS    = $clog2(DEPTH + 1);

  logic                                   in_valid_i;
  logic [RESULT_BITS-1:0]                 result_i;
  logic [31:0]                            ip_addr_i;
  logic                                   out_valid_o;
  logic                                   out_ready_i;
  logic [31:0]                            out_ip_addr_o;
  logic                                   out_match_o;
  logic [1:0]                             out_child_o;
  logic [STAGE_ID_BITS-1:0]               out_stage_id_o;
  logic [LOCATION_BITS-1:0]               out_location_o;
  logic [STAGE_ID_BITS+LOCATION_BITS-1:0] out_index_o;
  logic [CNT_BITS-1:0]                    count_o;
  logic                                   almost_full_o;
  logic                                   overflow_o;

  modport slave (
    input  in_valid_i, result_i, ip_addr_i, out_ready_i,
    output out_valid_o, out_ip_addr_o, out_match_o, out_child_o,
           out_stage_id_o, out_location_o, out_index_o,
           count_o, almost_full_o, overflow_o
  );

  modport master (
    output in_valid_i, result_i, ip_addr_i, out_ready_i,
    input  out_valid_o, out_ip_addr_o, out_match_o, out_child_o,
           out_stage_id_o, out_location_o, out_index_o,
           count_o, almost_full_o, overflow_o
  );
endinterface

// File: rtl/sbp_result_collect.sv
// Non-stalling FWFT capture FIFO for lookup results with head decode and a
// registered almost-full credit. Optional counters: define SBP_COLLECT_STATS_EN.
module sbp_result_collect #(
  parameter int STAGE_ID_BITS = 6,
  parameter int LOCATION_BITS = 11,
  parameter int DEPTH         = 64,
  parameter int AF_MARGIN     = 34
) (
  input  logic                 clk,
  input  logic                 rst,
  sbp_result_collect_if.slave  bus
`ifdef SBP_COLLECT_STATS_EN
  ,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o,
  output logic [31:0]          drop_cnt_o
`endif
);
  localparam int RESULT_BITS = 1 + LOCATION_BITS + 2 + STAGE_ID_BITS;
  localparam int CNT_BITS    = $clog2(DEPTH + 1);
  localparam int PTR_BITS    = $clog2(DEPTH);
  localparam int ENTRY_BITS  = 32 + RESULT_BITS;
  localparam logic [CNT_BITS-1:0] FULL_LEVEL = CNT_BITS'(DEPTH);
  localparam logic [CNT_BITS-1:0] AF_LEVEL   = CNT_BITS'(DEPTH - AF_MARGIN);

  logic [ENTRY_BITS-1:0] r_mem [DEPTH];
  logic [PTR_BITS-1:0]   r_wr_ptr;
  logic [PTR_BITS-1:0]   r_rd_ptr;
  logic [CNT_BITS-1:0]   r_count;
  logic                  r_almost_full;
  logic                  r_overflow;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [CNT_BITS-1:0]   w_count_nxt;
  logic [ENTRY_BITS-1:0] w_head;
  logic [RESULT_BITS-1:0] w_head_res;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_LEVEL);
  assign w_pop   = !w_empty && bus.out_ready_i;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push  = bus.in_valid_i && (!w_full || w_pop);
  assign w_drop  = bus.in_valid_i && w_full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_BITS'(1);
      2'b01:   w_count_nxt = r_count - CNT_BITS'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
      r_count       <= w_count_nxt;
      r_almost_full <= (w_count_nxt >= AF_LEVEL);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; occupancy and pointers define
  // validity, which lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= {bus.ip_addr_i, bus.result_i};
  end

  // Head is forced to zero while empty so outputs read 0 after reset.
  assign w_head     = w_empty ? '0 : r_mem[r_rd_ptr];
  assign w_head_res = w_head[RESULT_BITS-1:0];

  assign bus.out_valid_o    = !w_empty;
  assign bus.out_ip_addr_o  = w_head[ENTRY_BITS-1:RESULT_BITS];
  assign bus.out_match_o    = w_head_res[RESULT_BITS-1];
  assign bus.out_location_o = w_head_res[RESULT_BITS-2 -: LOCATION_BITS];
  assign bus.out_child_o    = w_head_res[STAGE_ID_BITS+1 -: 2];
  assign bus.out_stage_id_o = w_head_res[STAGE_ID_BITS-1:0];
  assign bus.out_index_o    = {bus.out_stage_id_o, bus.out_location_o};
  assign bus.count_o        = r_count;
  assign bus.almost_full_o  = r_almost_full;
  assign bus.overflow_o     = r_overflow;

`ifdef SBP_COLLECT_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;
  logic [31:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push && bus.result_i[RESULT_BITS-1] && (r_hit_cnt != '1))
        r_hit_cnt <= r_hit_cnt + 32'd1;
      if (w_push && !bus.result_i[RESULT_BITS-1] && (r_miss_cnt != '1))
        r_miss_cnt <= r_miss_cnt + 32'd1;
      if (w_drop && (r_drop_cnt != '1))
        r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
  assign drop_cnt_o = r_drop_cnt;
`endif
endmodule
